// File: rtl/dm_arb_pkg.sv
// ----------------------------------------------------------------------------
// dm_arb_pkg
// Shared types and constants for the data-memory access arbiter.
//   arb_state_e    : arbiter FSM encoding (IDLE -> BURST -> DRAIN -> IDLE)
//   arb_src_e      : which requester owns the memory port in the current cycle
//   STARVE_LIM_DEF : default count of consecutive core wins during a burst
//                    before a DMA beat is forced through
//   sat_inc16      : saturating 16-bit increment for the optional perf counters
// ----------------------------------------------------------------------------
package dm_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    typedef enum logic {
        SRC_CORE = 1'b0,
        SRC_DMA  = 1'b1
    } arb_src_e;

    localparam int STARVE_LIM_DEF = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dm_burst_addr_gen.sv
// ----------------------------------------------------------------------------
// dm_burst_addr_gen
// Holds the parameters of the accepted DMA burst and walks its beat index.
//   clk        in   clock
//   rst_ni     in   asynchronous active-low reset
//   load_i     in   burst accepted: capture base/len, restart at beat 0
//   base_i     in   burst start address
//   len_i      in   burst beat count
//   advance_i  in   a beat was issued this cycle: step to the next beat
//   addr_o     out  address of the current beat (base + index, wraps)
//   last_o     out  current beat is the final one of the burst
// ----------------------------------------------------------------------------
module dm_burst_addr_gen #(
    parameter int DMA_SIZE = 16,
    parameter int BURST_W  = 8
) (
    input  logic                clk,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [DMA_SIZE-1:0] base_i,
    input  logic [BURST_W-1:0]  len_i,
    input  logic                advance_i,
    output logic [DMA_SIZE-1:0] addr_o,
    output logic                last_o
);

    logic [DMA_SIZE-1:0] base_q, base_d;
    logic [BURST_W-1:0]  len_q, len_d;
    logic [BURST_W-1:0]  beat_idx_q, beat_idx_d;

    always_comb begin
        base_d     = base_q;
        len_d      = len_q;
        beat_idx_d = beat_idx_q;
        if (load_i) begin
            base_d     = base_i;
            len_d      = len_i;
            beat_idx_d = '0;
        end else if (advance_i) begin
            beat_idx_d = beat_idx_q + BURST_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q     <= '0;
            len_q      <= '0;
            beat_idx_q <= '0;
        end else begin
            base_q     <= base_d;
            len_q      <= len_d;
            beat_idx_q <= beat_idx_d;
        end
    end

    // Sum is truncated to the address width so a burst near the top of the
    // map wraps to address 0.
    assign addr_o = base_q + DMA_SIZE'(beat_idx_q);

    // Only meaningful while a burst is active; zero-length bursts never
    // reach the beat phase, so len_q-1 underflow is harmless.
    assign last_o = (beat_idx_q == (len_q - BURST_W'(1)));

endmodule

// File: rtl/dm_access_arbiter.sv
// ----------------------------------------------------------------------------
// dm_access_arbiter
// Shares the single data-memory port between the core load/store path and an
// external DMA burst requester. The core has priority; after STARVE_LIM
// consecutive core wins inside a burst, the next DMA beat is forced and the
// core is stalled for that cycle. Write data is registered into bc_dt so the
// memory sees it one cycle after the address (execute+1 write timing).
//
// Optional feature macro: DM_ARB_PERF_EN adds perf_stall_cnt / perf_beat_cnt.
//
// Ports
//   clk, reset                     clock, asynchronous active-low reset
//   core_dm_req/wrb/add/wdata      core access request
//   core_stall                     core request not issued this cycle
//   core_dm_rdata                  memory read data (one cycle after issue)
//   dma_req/wrb/base_add/len       burst request; wrb/base/len sampled at grant
//   dma_wdata                      write beat data, consumed when dma_wdata_rd
//   dma_gnt                        burst accepted (pulse, grant cycle)
//   dma_wdata_rd                   write beat consumed this cycle
//   dma_rvalid, dma_rdata          read beat data
//   dma_done                       burst complete (pulse, drain cycle)
//   ps_dm_cslt/ps_dm_wrb/dg_dm_add memory select / write enable / address
//   bc_dt                          registered memory write data
//   dm_bc_dt                       memory read data
//   perf_stall_cnt/perf_beat_cnt   (DM_ARB_PERF_EN only) saturating counters
// ----------------------------------------------------------------------------
module dm_access_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DMA_SIZE   = 16,
    parameter int DMD_SIZE   = 16,
    parameter int BURST_W    = 8,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                core_dm_req,
    input  logic                core_dm_wrb,
    input  logic [DMA_SIZE-1:0] core_dm_add,
    input  logic [DMD_SIZE-1:0] core_dm_wdata,
    output logic                core_stall,
    output logic [DMD_SIZE-1:0] core_dm_rdata,
    input  logic                dma_req,
    input  logic                dma_wrb,
    input  logic [DMA_SIZE-1:0] dma_base_add,
    input  logic [BURST_W-1:0]  dma_len,
    input  logic [DMD_SIZE-1:0] dma_wdata,
    output logic                dma_gnt,
    output logic                dma_wdata_rd,
    output logic                dma_rvalid,
    output logic [DMD_SIZE-1:0] dma_rdata,
    output logic                dma_done,
`ifdef DM_ARB_PERF_EN
    output logic [15:0]         perf_stall_cnt,
    output logic [15:0]         perf_beat_cnt,
`endif
    output logic                ps_dm_cslt,
    output logic                ps_dm_wrb,
    output logic [DMA_SIZE-1:0] dg_dm_add,
    output logic [DMD_SIZE-1:0] bc_dt,
    input  logic [DMD_SIZE-1:0] dm_bc_dt
);

    localparam int STW = $clog2(STARVE_LIM + 1);

    arb_state_e          state_q, state_d;
    logic [STW-1:0]      starve_q, starve_d;
    logic                burst_wrb_q, burst_wrb_d;
    logic [DMD_SIZE-1:0] bc_dt_q, bc_dt_d;
    logic                dma_rvalid_q, dma_rvalid_d;

    logic                issue;
    arb_src_e            src_sel;
    logic                stall;
    logic                gnt;
    logic                load;
    logic                advance;
    logic                issue_wrb;
    logic [DMA_SIZE-1:0] issue_add;
    logic [DMD_SIZE-1:0] issue_wdata;
    logic [DMA_SIZE-1:0] beat_addr;
    logic                beat_last;

    dm_burst_addr_gen #(
        .DMA_SIZE (DMA_SIZE),
        .BURST_W  (BURST_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_ni    (reset),
        .load_i    (load),
        .base_i    (dma_base_add),
        .len_i     (dma_len),
        .advance_i (advance),
        .addr_o    (beat_addr),
        .last_o    (beat_last)
    );

    // ------------------------------------------------------------------
    // Next state and issue decision
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        issue    = 1'b0;
        src_sel  = SRC_CORE;
        stall    = 1'b0;
        gnt      = 1'b0;
        load     = 1'b0;
        advance  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (core_dm_req) begin
                    issue = 1'b1;
                end else if (dma_req) begin
                    // Grant cycle: nothing reaches memory, parameters latch.
                    gnt      = 1'b1;
                    load     = 1'b1;
                    starve_d = '0;
                    state_d  = (dma_len == '0) ? ST_DRAIN : ST_BURST;
                end
            end

            ST_BURST: begin
                if (core_dm_req && (starve_q < STW'(STARVE_LIM))) begin
                    issue    = 1'b1;
                    starve_d = starve_q + STW'(1);
                end else begin
                    issue    = 1'b1;
                    src_sel  = SRC_DMA;
                    advance  = 1'b1;
                    starve_d = '0;
                    stall    = core_dm_req;
                    if (beat_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // Final beat is completing in memory; core may still go.
                issue   = core_dm_req;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Issue mux
    // ------------------------------------------------------------------
    assign issue_wrb   = (src_sel == SRC_DMA) ? burst_wrb_q : core_dm_wrb;
    assign issue_add   = (src_sel == SRC_DMA) ? beat_addr   : core_dm_add;
    assign issue_wdata = (src_sel == SRC_DMA) ? dma_wdata   : core_dm_wdata;

    always_comb begin
        burst_wrb_d  = load ? dma_wrb : burst_wrb_q;
        bc_dt_d      = (issue && issue_wrb) ? issue_wdata : bc_dt_q;
        dma_rvalid_d = issue && (src_sel == SRC_DMA) && !burst_wrb_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            starve_q     <= '0;
            burst_wrb_q  <= 1'b0;
            bc_dt_q      <= '0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            burst_wrb_q  <= burst_wrb_d;
            bc_dt_q      <= bc_dt_d;
            dma_rvalid_q <= dma_rvalid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Combinational paths are gated by reset so every output is
    // forced low the instant reset is asserted, even with requests held.
    // ------------------------------------------------------------------
    assign ps_dm_cslt    = reset & issue;
    assign ps_dm_wrb     = reset & issue & issue_wrb;
    assign dg_dm_add     = (reset && issue) ? issue_add : '0;
    assign core_stall    = reset & stall;
    assign dma_wdata_rd  = reset & issue & (src_sel == SRC_DMA) & burst_wrb_q;
    assign dma_gnt       = reset & gnt;
    assign dma_done      = reset & (state_q == ST_DRAIN);
    assign dma_rvalid    = dma_rvalid_q;
    assign bc_dt         = bc_dt_q;
    assign core_dm_rdata = reset ? dm_bc_dt : '0;
    assign dma_rdata     = reset ? dm_bc_dt : '0;

`ifdef DM_ARB_PERF_EN
    logic [15:0] perf_stall_q, perf_stall_d;
    logic [15:0] perf_beat_q, perf_beat_d;

    always_comb begin
        perf_stall_d = stall ? sat_inc16(perf_stall_q) : perf_stall_q;
        perf_beat_d  = advance ? sat_inc16(perf_beat_q) : perf_beat_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_q <= '0;
            perf_beat_q  <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_beat_q  <= perf_beat_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_beat_cnt  = perf_beat_q;
`endif

endmodule

// File: tb/tb_dm_access_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dm_access_arbiter
// Self-checking bench: each driven cycle pushes its expected outputs onto a
// queue; a negedge monitor pops and compares. A small behavioural memory
// commits writes one cycle after issue and returns read data one cycle after
// issue.
// ----------------------------------------------------------------------------
module tb_dm_access_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_dm_req, core_dm_wrb;
    logic [15:0] core_dm_add, core_dm_wdata;
    logic        core_stall;
    logic [15:0] core_dm_rdata;
    logic        dma_req, dma_wrb;
    logic [15:0] dma_base_add;
    logic [7:0]  dma_len;
    logic [15:0] dma_wdata;
    logic        dma_gnt, dma_wdata_rd, dma_rvalid, dma_done;
    logic [15:0] dma_rdata;
    logic        ps_dm_cslt, ps_dm_wrb;
    logic [15:0] dg_dm_add, bc_dt, dm_bc_dt;
`ifdef DM_ARB_PERF_EN
    logic [15:0] perf_stall_cnt, perf_beat_cnt;
`endif

    always #5 clk = ~clk;

    dm_access_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .core_dm_req   (core_dm_req),
        .core_dm_wrb   (core_dm_wrb),
        .core_dm_add   (core_dm_add),
        .core_dm_wdata (core_dm_wdata),
        .core_stall    (core_stall),
        .core_dm_rdata (core_dm_rdata),
        .dma_req       (dma_req),
        .dma_wrb       (dma_wrb),
        .dma_base_add  (dma_base_add),
        .dma_len       (dma_len),
        .dma_wdata     (dma_wdata),
        .dma_gnt       (dma_gnt),
        .dma_wdata_rd  (dma_wdata_rd),
        .dma_rvalid    (dma_rvalid),
        .dma_rdata     (dma_rdata),
        .dma_done      (dma_done),
`ifdef DM_ARB_PERF_EN
        .perf_stall_cnt(perf_stall_cnt),
        .perf_beat_cnt (perf_beat_cnt),
`endif
        .ps_dm_cslt    (ps_dm_cslt),
        .ps_dm_wrb     (ps_dm_wrb),
        .dg_dm_add     (dg_dm_add),
        .bc_dt         (bc_dt),
        .dm_bc_dt      (dm_bc_dt)
    );

    // Memory model: address in issue cycle, write data (bc_dt) committed on
    // the following edge; read data available the cycle after issue.
    logic [15:0] mem [0:65535];
    logic        pend_wr = 1'b0;
    logic [15:0] pend_addr = '0;
    logic [15:0] rd_q = '0;

    always @(posedge clk) begin
        pend_wr   <= ps_dm_cslt & ps_dm_wrb;
        pend_addr <= dg_dm_add;
        if (pend_wr) mem[pend_addr] <= bc_dt;
        if (ps_dm_cslt && !ps_dm_wrb) rd_q <= mem[dg_dm_add];
    end
    assign dm_bc_dt = rd_q;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ctl = {cslt, wrb, stall, gnt, done, wdata_rd, rvalid}
    typedef struct {
        string       tag;
        logic [6:0]  ctl;
        logic [15:0] ad;
        logic        bc_en;
        logic [15:0] bc;
        logic        rd_en;
        logic [15:0] rd;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t mk(input string tag, input logic cs, input logic wr,
                                input logic [15:0] ad, input logic st, input logic gn,
                                input logic dn, input logic wrd, input logic rv);
        exp_t e;
        e.tag   = tag;
        e.ctl   = {cs, wr, st, gn, dn, wrd, rv};
        e.ad    = ad;
        e.bc_en = 1'b0;
        e.bc    = '0;
        e.rd_en = 1'b0;
        e.rd    = '0;
        return e;
    endfunction

    function automatic exp_t with_bc(input exp_t e_in, input logic [15:0] bc);
        exp_t e = e_in;
        e.bc_en = 1'b1;
        e.bc    = bc;
        return e;
    endfunction

    function automatic exp_t with_rd(input exp_t e_in, input logic [15:0] rd);
        exp_t e = e_in;
        e.rd_en = 1'b1;
        e.rd    = rd;
        return e;
    endfunction

    logic [6:0] ctl_obs;
    assign ctl_obs = {ps_dm_cslt, ps_dm_wrb, core_stall, dma_gnt, dma_done, dma_wdata_rd, dma_rvalid};

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("TXN %-6s cs=%b wr=%b addr=%h stall=%b gnt=%b done=%b wrd=%b rv=%b bc=%h rdata=%h",
                     e.tag, ps_dm_cslt, ps_dm_wrb, dg_dm_add, core_stall, dma_gnt, dma_done,
                     dma_wdata_rd, dma_rvalid, bc_dt, dm_bc_dt);
            check_val({e.tag, ".ctl"}, 32'(ctl_obs), 32'(e.ctl));
            check_val({e.tag, ".addr"}, 32'(dg_dm_add), 32'(e.ad));
            if (e.bc_en) check_val({e.tag, ".bc_dt"}, 32'(bc_dt), 32'(e.bc));
            if (e.rd_en) begin
                if (e.ctl[0]) check_val({e.tag, ".dma_rdata"}, 32'(dma_rdata), 32'(e.rd));
                else          check_val({e.tag, ".core_rdata"}, 32'(core_dm_rdata), 32'(e.rd));
            end
        end
    end

    // One driven cycle: queue its expectation, advance to just past the edge.
    task automatic step(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input logic req, input logic wrb, input logic [15:0] add, input logic [15:0] wd);
        core_dm_req = req; core_dm_wrb = wrb; core_dm_add = add; core_dm_wdata = wd;
    endtask

    task automatic set_dma(input logic req, input logic wrb, input logic [15:0] base, input logic [7:0] len);
        dma_req = req; dma_wrb = wrb; dma_base_add = base; dma_len = len;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        set_core(1'b1, 1'b0, 16'h0010, 16'h0000);
        set_dma(1'b1, 1'b0, 16'h0000, 8'd0);
        dma_wdata = '0;

        // Reset state: outputs low even with both requests asserted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst.ctl", 32'(ctl_obs), 32'd0);
        check_val("rst.addr", 32'(dg_dm_add), 32'd0);
        check_val("rst.bc_dt", 32'(bc_dt), 32'd0);
        check_val("rst.core_rdata", 32'(core_dm_rdata), 32'd0);
        @(posedge clk); #1;
        set_core(1'b0, 1'b0, 16'h0000, 16'h0000);
        set_dma(1'b0, 1'b0, 16'h0000, 8'd0);
        reset = 1'b1;

        // Core only: write 0xBEEF to 0x0010, then read it back.
        set_core(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        step(mk("cw", 1, 1, 16'h0010, 0, 0, 0, 0, 0));
        set_core(1'b0, 1'b0, 16'h0000, 16'h0000);
        step(with_bc(mk("cw+1", 0, 0, 16'h0000, 0, 0, 0, 0, 0), 16'hBEEF));
        set_core(1'b1, 1'b0, 16'h0010, 16'h0000);
        step(mk("cr", 1, 0, 16'h0010, 0, 0, 0, 0, 0));
        set_core(1'b0, 1'b0, 16'h0000, 16'h0000);
        step(with_rd(mk("cr+1", 0, 0, 16'h0000, 0, 0, 0, 0, 0), 16'hBEEF));

        // DMA write burst: base 0x0100, len 4, data 1..4; request dropped
        // after grant (committed length still completes).
        set_dma(1'b1, 1'b1, 16'h0100, 8'd4);
        step(mk("wg", 0, 0, 16'h0000, 0, 1, 0, 0, 0));
        set_dma(1'b0, 1'b0, 16'h0000, 8'd0);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            dma_wdata = 16'(i + 1);
            e = mk($sformatf("wb%0d", i), 1, 1, 16'h0100 + 16'(i), 0, 0, 0, 1, 0);
            if (i > 0) e = with_bc(e, 16'(i));
            step(e);
        end
        dma_wdata = 16'h0000;
        step(with_bc(mk("wd", 0, 0, 16'h0000, 0, 0, 1, 0, 0), 16'd4));
        step(mk("wi", 0, 0, 16'h0000, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            check_val($sformatf("mem[%h]", 16'h0100 + 16'(i)), 32'(mem[16'h0100 + 16'(i)]), 32'(i + 1));

        // Starvation: len-2 read of 0x0100.. while the core reads every cycle.
        set_dma(1'b1, 1'b0, 16'h0100, 8'd2);
        step(mk("sg", 0, 0, 16'h0000, 0, 1, 0, 0, 0));
        set_dma(1'b0, 1'b0, 16'h0000, 8'd0);
        set_core(1'b1, 1'b0, 16'h0010, 16'h0000);
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (k == 1 && j == 0)
                    step(with_rd(mk("sc", 1, 0, 16'h0010, 0, 0, 0, 0, 1), 16'd1));
                else
                    step(mk($sformatf("sc%0d%0d", k, j), 1, 0, 16'h0010, 0, 0, 0, 0, 0));
            end
            step(mk($sformatf("sd%0d", k), 1, 0, 16'h0100 + 16'(k), 1, 0, 0, 0, 0));
        end
        step(with_rd(mk("sdr", 1, 0, 16'h0010, 0, 0, 1, 0, 1), 16'd2));
        set_core(1'b0, 1'b0, 16'h0000, 16'h0000);
        step(mk("si", 0, 0, 16'h0000, 0, 0, 0, 0, 0));

        // Address wrap: base 0xFFFF, len 2.
        set_dma(1'b1, 1'b1, 16'hFFFF, 8'd2);
        step(mk("xg", 0, 0, 16'h0000, 0, 1, 0, 0, 0));
        set_dma(1'b0, 1'b0, 16'h0000, 8'd0);
        dma_wdata = 16'h0011;
        step(mk("xb0", 1, 1, 16'hFFFF, 0, 0, 0, 1, 0));
        dma_wdata = 16'h0022;
        step(with_bc(mk("xb1", 1, 1, 16'h0000, 0, 0, 0, 1, 0), 16'h0011));
        dma_wdata = 16'h0000;
        step(with_bc(mk("xd", 0, 0, 16'h0000, 0, 0, 1, 0, 0), 16'h0022));
        step(mk("xi", 0, 0, 16'h0000, 0, 0, 0, 0, 0));
        check_val("mem[ffff]", 32'(mem[16'hFFFF]), 32'h0011);
        check_val("mem[0000]", 32'(mem[16'h0000]), 32'h0022);

        // IDLE contention: core wins, grant on the first core-idle cycle.
        set_dma(1'b1, 1'b0, 16'h0010, 8'd1);
        set_core(1'b1, 1'b1, 16'h0400, 16'h5555);
        step(mk("cc", 1, 1, 16'h0400, 0, 0, 0, 0, 0));
        set_core(1'b0, 1'b0, 16'h0000, 16'h0000);
        step(with_bc(mk("cg", 0, 0, 16'h0000, 0, 1, 0, 0, 0), 16'h5555));
        set_dma(1'b0, 1'b0, 16'h0000, 8'd0);
        step(mk("cb", 1, 0, 16'h0010, 0, 0, 0, 0, 0));
        step(with_rd(mk("cdn", 0, 0, 16'h0000, 0, 0, 1, 0, 1), 16'hBEEF));

        // Zero-length burst with request held: grant, done, re-grant, done.
        set_dma(1'b1, 1'b0, 16'h0200, 8'd0);
        step(mk("zg", 0, 0, 16'h0000, 0, 1, 0, 0, 0));
        step(mk("zd", 0, 0, 16'h0000, 0, 0, 1, 0, 0));
        step(mk("zg2", 0, 0, 16'h0000, 0, 1, 0, 0, 0));
        set_dma(1'b0, 1'b0, 16'h0000, 8'd0);
        step(mk("zd2", 0, 0, 16'h0000, 0, 0, 1, 0, 0));
        step(mk("zi", 0, 0, 16'h0000, 0, 0, 0, 0, 0));

        // Reset mid-burst: abort after beat 2 of 4.
        set_dma(1'b1, 1'b1, 16'h0500, 8'd4);
        step(mk("rg", 0, 0, 16'h0000, 0, 1, 0, 0, 0));
        set_dma(1'b0, 1'b0, 16'h0000, 8'd0);
        dma_wdata = 16'd9;
        step(mk("rb0", 1, 1, 16'h0500, 0, 0, 0, 1, 0));
        dma_wdata = 16'd10;
        step(with_bc(mk("rb1", 1, 1, 16'h0501, 0, 0, 0, 1, 0), 16'd9));
        dma_wdata = 16'd11;
        #1;
        check_val("rb2.pre_cslt", 32'(ps_dm_cslt), 32'd1);
        reset = 1'b0;
        #1;
        check_val("rab.ctl", 32'(ctl_obs), 32'd0);
        check_val("rab.addr", 32'(dg_dm_add), 32'd0);
        check_val("rab.bc_dt", 32'(bc_dt), 32'd0);
        @(negedge clk);
        check_val("rab.done", 32'(dma_done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        set_dma(1'b1, 1'b1, 16'h0500, 8'd2);
        step(mk("ng", 0, 0, 16'h0000, 0, 1, 0, 0, 0));
        set_dma(1'b0, 1'b0, 16'h0000, 8'd0);
        dma_wdata = 16'h0077;
        step(mk("nb0", 1, 1, 16'h0500, 0, 0, 0, 1, 0));
        dma_wdata = 16'h0078;
        step(with_bc(mk("nb1", 1, 1, 16'h0501, 0, 0, 0, 1, 0), 16'h0077));
        dma_wdata = 16'h0000;
        step(with_bc(mk("nd", 0, 0, 16'h0000, 0, 0, 1, 0, 0), 16'h0078));
        step(mk("ni", 0, 0, 16'h0000, 0, 0, 0, 0, 0));

        @(negedge clk);
        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
